// File: rtl/fsm_arb_pkg.sv
// Shared constants for the grant FSM family: state encoding, agent count, index width.
// Also provides the index-to-one-hot helper used to form registered grant vectors.
package fsm_arb_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  localparam int unsigned NUM_AGENTS = 4;
  localparam int unsigned IDX_W      = 2;

  function automatic logic [NUM_AGENTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_AGENTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester at or after ptr (mod 4) wins.
module rr_pick4
  import fsm_arb_pkg::*;
(
  input  logic [NUM_AGENTS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  valid,
  output logic [IDX_W-1:0]      winner
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // Walk from the farthest offset back so the requester nearest to ptr is kept last.
    for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Four-agent round-robin grant FSM with a one-cycle handover gap between grants.
// Define FSM_RR_ARB_TIMEOUT_EN to add the hold counter that revokes over-long grants.
module fsm_rr_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  logic                  state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      holder_q, holder_d;
  logic [NUM_AGENTS-1:0] gnt_q, gnt_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_winner;
  logic                  hold_req;
  logic                  revoke;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign hold_req = req[holder_q];

`ifdef FSM_RR_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] CntMax = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  assign revoke = (state_q == GRANT) && hold_req && (cnt_q == CntMax);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!hold_req || revoke) begin
      // A release on the saturating edge wins over the revoke: no pulse.
      cnt_d     = '0;
      timeout_d = revoke;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic [HOLD_W-1:0] unused_hold_cfg;
  assign unused_hold_cfg = HOLD_W'(MAX_HOLD);
  assign revoke          = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    holder_d = holder_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = GRANT;
          holder_d = pick_winner;
          gnt_d    = idx_to_onehot(pick_winner);
        end
      end
      GRANT: begin
        // Non-holder requests are ignored until the holder lets go or is revoked.
        if (!hold_req || revoke) begin
          state_d  = IDLE;
          holder_d = '0;
          gnt_d    = '0;
          ptr_d    = holder_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      holder_q  <= '0;
      gnt_q     <= '0;
`ifdef FSM_RR_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      holder_q  <= holder_d;
      gnt_q     <= gnt_d;
`ifdef FSM_RR_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = holder_q;
  assign busy   = (state_q == GRANT);

endmodule
